// File: rtl/demux_1to4_reg_if.sv
// ---------------------------------------------------------------------------
// demux_1to4_reg_if
// Bundles the producer handshake and the four consumer lanes of the
// registered 1-to-4 demultiplexer.
//   in_data    : word offered by the producer
//   sel        : target lane for in_data (0..3)
//   in_valid   : producer offers in_data/sel this cycle
//   in_ready   : demux can accept this cycle
//   out_data0-3: lane holding registers
//   out_valid  : bit i set while lane i holds an unconsumed word
//   out_ack    : bit i set when consumer i takes lane i's word
//   xfer_count : accepted transfers, modulo 2^CNT_W
// Modports: master = producer/consumer side, slave = demux side.
// ---------------------------------------------------------------------------
interface demux_1to4_reg_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ack;
    logic [CNT_W-1:0] xfer_count;

    modport master (
        output in_data, sel, in_valid, out_ack,
        input  in_ready, out_data0, out_data1, out_data2, out_data3,
               out_valid, xfer_count
    );

    modport slave (
        input  in_data, sel, in_valid, out_ack,
        output in_ready, out_data0, out_data1, out_data2, out_data3,
               out_valid, xfer_count
    );
endinterface

// File: rtl/demux_1to4_reg.sv
// ---------------------------------------------------------------------------
// demux_1to4_reg
// Registered 1-to-4 demultiplexer. One producer stream is steered by sel
// into one of four holding registers; each lane keeps its word until its
// consumer acknowledges it. The producer is stalled only when the lane it
// addresses is still occupied and not being acknowledged this cycle.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : demux_1to4_reg_if slave modport (data, handshakes, counter)
// ---------------------------------------------------------------------------
module demux_1to4_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    demux_1to4_reg_if.slave       bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } laneState_t;

    laneState_t       r_laneState [4];
    logic [WIDTH-1:0] r_outData   [4];
    logic [CNT_W-1:0] r_xferCount;

    logic             w_inReady;
    logic             w_accept;
    logic [3:0]       w_outValid;

    // Ready looks only at the addressed lane; an ack on that lane frees it
    // in the same cycle so a full lane can be refilled without a bubble.
    always_comb begin
        w_inReady = rst && ((r_laneState[bus.sel] == EMPTY) || bus.out_ack[bus.sel]);
        w_accept  = bus.in_valid && w_inReady;
    end

    always_comb begin
        w_outValid = '0;
        for (int i = 0; i < 4; i++) begin
            w_outValid[i] = (r_laneState[i] == FULL);
        end
    end

    // Per-lane EMPTY/FULL machines plus holding registers. An accept to a
    // lane wins over its ack, so ack+accept keeps the lane FULL with the new
    // word. Data is never cleared by an ack, only overwritten or reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_laneState[i] <= EMPTY;
                r_outData[i]   <= '0;
            end
            r_xferCount <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (r_laneState[i])
                    EMPTY: begin
                        if (w_accept && (bus.sel == 2'(i))) begin
                            r_laneState[i] <= FULL;
                            r_outData[i]   <= bus.in_data;
                        end
                    end
                    FULL: begin
                        if (w_accept && (bus.sel == 2'(i))) begin
                            r_outData[i] <= bus.in_data;
                        end else if (bus.out_ack[i]) begin
                            r_laneState[i] <= EMPTY;
                        end
                    end
                    default: r_laneState[i] <= EMPTY;
                endcase
            end
            if (w_accept) begin
                r_xferCount <= r_xferCount + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready   = w_inReady;
    assign bus.out_data0  = r_outData[0];
    assign bus.out_data1  = r_outData[1];
    assign bus.out_data2  = r_outData[2];
    assign bus.out_data3  = r_outData[3];
    assign bus.out_valid  = w_outValid;
    assign bus.xfer_count = r_xferCount;

endmodule

// File: doc/demux_1to4_reg.md
# demux_1to4_reg

Registered 1-to-4 demultiplexer with per-lane valid/acknowledge handshake. It is the distributing counterpart of `mux_4to1`: a single 32-bit producer stream is steered by `sel` into one of four output holding registers. Each lane holds its word until its consumer acknowledges it. It sits between a pipeline stage result and four downstream consumers, for example forwarding or write-back lanes, and back-pressures the producer when the addressed lane is still occupied.

## Interface
Parameters:
- WIDTH, 32, data width of input and each output lane
- CNT_W, 8, width of the accepted-transfer counter

Ports:
- clk  input  1  single clock, rising-edge active
- rst  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  word to distribute
- sel  input  2  target lane: 00→lane 0, 01→lane 1, 10→lane 2, 11→lane 3
- in_valid  input  1  producer offers in_data/sel this cycle
- in_ready  output  1  block accepts this cycle; transfer occurs when in_valid && in_ready at a rising edge
- out_data0..out_data3  output  WIDTH each  lane holding registers
- out_valid  output  4  bit i set means lane i holds an unconsumed word
- out_ack  input  4  bit i: consumer i takes lane i's word this cycle
- xfer_count  output  CNT_W  number of accepted input transfers, modulo 2^CNT_W

## Operation
- Each lane is a two-state machine.
  - EMPTY (out_valid[i]=0): goes to FULL on an accept with sel=i.
  - FULL (out_valid[i]=1): goes to EMPTY on out_ack[i] with no accept to lane i. It stays FULL on accept to lane i, with or without ack. It stays FULL without ack.
- in_ready = rst && (!out_valid[sel] || out_ack[sel]). This path is combinational, so a FULL lane acked this cycle can be refilled in the same cycle.
- in_ready depends only on the addressed lane. Occupancy of other lanes never stalls the producer.
- On accept: out_data[sel] <= in_data, out_valid[sel] <= 1, xfer_count <= xfer_count + 1. The counter wraps from 2^CNT_W−1 to 0.
- Lanes not addressed by an accept keep their data.
- Acks are independent per lane. Several lanes may be acked in the same cycle.
- out_ack[i] while lane i is EMPTY is ignored and has no effect.
- out_data is not cleared on ack. The last value remains visible with out_valid low.
- in_valid low: sel and in_data are don't-care. No state changes except acks.
- The design is fully synchronous apart from reset. There are no combinational paths from in_data to out_data.

## Timing
- Reset values (asynchronous, while rst=0):
  - out_data0..3 = 0
  - out_valid = 4'b0000
  - xfer_count = 0
  - in_ready = 0
- First accept is possible on the first rising edge after rst deasserts.
- Latency: a word accepted at edge N appears on out_data[sel] with out_valid[sel]=1 right after edge N, so it is visible in cycle N+1.
- An ack sampled at edge M clears out_valid[i] after edge M, unless lane i is refilled at the same edge.
- Throughput per lane: 1 word/cycle when the consumer acks every cycle. Throughput across lanes: 1 word/cycle total.
- Reset mid-operation discards all held words and the count immediately, with no waiting for the clock. Pending acks are irrelevant.
- Simultaneous ack and accept on the same lane: new data loaded, out_valid stays 1, xfer_count increments.

## Test plan
- Reset and fill: hold rst=0 with in_valid=1, confirm all outputs 0 and in_ready=0. Release rst, then send A=32'h80000000 sel=00, B=32'h80000001 sel=01, C=32'h80000002 sel=10, D=32'h80000003 sel=11 on consecutive cycles → out_data0..3 = those words, out_valid=4'b1111, xfer_count=4.
- Back-pressure: lane 2 FULL with 32'h80000002 and no ack, offer 32'hDEADBEEF sel=10 → in_ready=0, lane 2 unchanged, xfer_count unchanged. Assert out_ack[2] → in_ready=1 that cycle, lane 2 becomes 32'hDEADBEEF, out_valid[2] stays 1.
- Lane independence: lane 0 FULL and unacked, offer 32'h12345678 sel=01 with lane 1 EMPTY → accepted, out_data1=32'h12345678, out_data0 unchanged.
- Ack handling: ack lanes 0 and 3 together → out_valid goes from 4'b1111 to 4'b0110 and out_data0/out_data3 retain their values. Ack an EMPTY lane → no change.
- Streaming and wrap: sel=00 with out_ack[0] held high, 256 consecutive accepts of incrementing data → one accept per cycle, out_data0 tracks input with one-cycle latency, xfer_count returns to 0.
- Reset mid-stream: drop rst asynchronously between edges while lanes are FULL → out_valid=0, data=0, count=0 immediately. Release rst and resume → normal operation.
